s2mm_writer: RTL
================

# s2mm_writer

Stream-to-memory-mapped writer forming the data-moving end of the quad-buffer sync interface. Accepts samples from an AXI4-Stream source, writes each sample as a single-beat AXI4 write to the address supplied on `SM_write_buffer`, and reports progress back through `SM_reading` (sample accepted) and `SM_writing` (write acknowledged), which the sync manager uses to advance its buffer counters. Sits between the signal-processing chain and the PS HP port.

## Interface

- `MM_ADDR_WIDTH`, 32, AXI address width and width of `SM_write_buffer`
- `DATA_WIDTH`, 32, stream and AXI data width; 32 or 64 only
- `SYS_aclk`  in  1  system clock; everything is synchronous to its rising edge
- `SYS_aresetn`  in  1  reset, asynchronous assert, active-low
- `S_AXIS_tdata`  in  DATA_WIDTH  sample data
- `S_AXIS_tvalid`  in  1  sample valid
- `S_AXIS_tready`  out  1  sample accepted when high together with tvalid
- `SM_write_buffer`  in  MM_ADDR_WIDTH  byte address for the next accepted sample
- `SM_reading`  out  1  one-cycle pulse, sample accepted
- `SM_writing`  out  1  one-cycle pulse, write response received
- `M_AXI_awaddr`  out  MM_ADDR_WIDTH  write address
- `M_AXI_awlen` / `awsize` / `awburst` / `awcache` / `awprot`  out  8/3/2/4/3  constants 0, log2(DATA_WIDTH/8), 2'b01, 4'b0011, 3'b000
- `M_AXI_awvalid`, `M_AXI_awready`  out/in  1  address handshake
- `M_AXI_wdata`  out  DATA_WIDTH  write data
- `M_AXI_wstrb`  out  DATA_WIDTH/8  constant all ones
- `M_AXI_wlast`  out  1  constant 1
- `M_AXI_wvalid`, `M_AXI_wready`  out/in  1  data handshake
- `M_AXI_bresp`  in  2  write response
- `M_AXI_bvalid`, `M_AXI_bready`  in/out  1  response handshake
- `S2MM_error_count`  out  32  count of non-OKAY responses (present only with the macro below)

## Operation

- FSM states: IDLE, XFER, RESP.
- IDLE: `S_AXIS_tready`=1. On `S_AXIS_tvalid`: latch tdata into data register, latch `SM_write_buffer` into address register, go to XFER.
- `SM_reading` = `S_AXIS_tvalid & S_AXIS_tready` (combinational), so the sync manager advances its sample offset at the same edge that latches the address.
- XFER: `awvalid` and `wvalid` both asserted on entry. Each deasserts independently after its own handshake (`awready` / `wready` may arrive in either order or the same cycle). Go to RESP in the cycle after both handshakes are complete. tready=0.
- RESP: `bready`=1. On `bvalid`: `SM_writing` = `bvalid & bready` (combinational), go to IDLE.
- One transaction outstanding at any time; data and address registers are stable from latch until RESP exits.
- `awaddr` and `wdata` drive the latched registers; unchanged while valid is high (AXI stability rule).
- Any `bresp` value completes the transaction; `SM_writing` pulses regardless of response.

## Timing

- Reset values: `S_AXIS_tready`=0 while reset asserted and 1 from the first edge after release (state IDLE), `SM_reading`=0, `SM_writing`=0, `awvalid`=0, `wvalid`=0, `bready`=0, address/data registers 0, error count 0.
- Reset assertion mid-transaction clears all valids immediately (asynchronous); the transaction is abandoned and no pulse is emitted.
- Latency with zero-wait slave (awready, wready, bvalid all high): accept at edge N, aw/w handshake at N+1, bready high at N+2, response at N+2, IDLE at N+3, next accept at N+3. Throughput: one sample per 3 cycles.
- Source stalls are permitted; tready never depends combinationally on AXI inputs.
- `SM_reading` and `SM_writing` never assert in the same cycle.

## Configuration

- `S2MM_WRITER_ERROR_COUNT_EN` defined: port `S2MM_error_count` exists; incremented by 1 on each B handshake with `bresp` ≠ 2'b00, saturating at 32'hFFFF_FFFF; reset clears it.
- Undefined: port absent, `bresp` ignored, no counter logic.

## Test plan

- Reset release, tvalid=1, tdata=0x11223344, SM_write_buffer=0x1E00_0000, zero-wait slave -> SM_reading pulse at accept, awaddr=0x1E00_0000 / wdata=0x11223344 one cycle later, SM_writing pulse two cycles after accept.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready asserted only after both handshakes.
- Continuous stream of 8 samples, SM_write_buffer advanced by 4 per SM_reading -> 8 writes at base+0..base+28, sample spacing exactly 3 cycles.
- bvalid withheld 10 cycles -> tready stays 0, no SM_writing until bvalid; then single pulse.
- Reset asserted while awvalid=1 -> awvalid, wvalid low within same cycle, no SM_writing; after release first accepted sample written normally.
- Macro defined, responses OKAY, SLVERR, DECERR -> S2MM_error_count = 0, 1, 2; counter preset near saturation stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/s2mm_writer.sv
// Stream-to-MM writer: one AXI-Stream sample becomes one single-beat AXI4 write; optional S2MM_WRITER_ERROR_COUNT_EN adds a bresp error counter.
// Latency: accept at edge N, AW/W handshake at N+1 (zero-wait), B at N+2, next accept at N+3 (one sample per 3 cycles).
// Backpressure: tready is high only in IDLE, so one write is outstanding; tready depends on state only, never on AXI inputs.
module s2mm_writer #(
   parameter int MM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                      SYS_aclk,
   input  logic                      SYS_aresetn,
   input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
   input  logic                      S_AXIS_tvalid,
   output logic                      S_AXIS_tready,
   input  logic [MM_ADDR_WIDTH-1:0]  SM_write_buffer,
   output logic                      SM_reading,
   output logic                      SM_writing,
   output logic [MM_ADDR_WIDTH-1:0]  M_AXI_awaddr,
   output logic [7:0]                M_AXI_awlen,
   output logic [2:0]                M_AXI_awsize,
   output logic [1:0]                M_AXI_awburst,
   output logic [3:0]                M_AXI_awcache,
   output logic [2:0]                M_AXI_awprot,
   output logic                      M_AXI_awvalid,
   input  logic                      M_AXI_awready,
   output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
   output logic                      M_AXI_wlast,
   output logic                      M_AXI_wvalid,
   input  logic                      M_AXI_wready,
   input  logic [1:0]                M_AXI_bresp,
   input  logic                      M_AXI_bvalid,
   output logic                      M_AXI_bready
`ifdef S2MM_WRITER_ERROR_COUNT_EN
   ,
   output logic [31:0]               S2MM_error_count
`endif
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   typedef struct packed {
      logic [MM_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    dat;
   } beat_t;

   localparam logic [2:0] AW_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

   state_t state_q, state_d;
   beat_t  beat_q;
   logic   run_q;
   logic   aw_vld_q, w_vld_q;
   logic   accept, aw_hs, w_hs, b_hs;
   logic   tready_c, bready_c;

   assign M_AXI_awlen   = 8'd0;
   assign M_AXI_awsize  = AW_SIZE;
   assign M_AXI_awburst = 2'b01;
   assign M_AXI_awcache = 4'b0011;
   assign M_AXI_awprot  = 3'b000;
   assign M_AXI_wstrb   = '1;
   assign M_AXI_wlast   = 1'b1;

   assign M_AXI_awaddr  = beat_q.addr;
   assign M_AXI_wdata   = beat_q.dat;
   assign M_AXI_awvalid = aw_vld_q;
   assign M_AXI_wvalid  = w_vld_q;
   assign S_AXIS_tready = tready_c;
   assign M_AXI_bready  = bready_c;

   assign accept     = S_AXIS_tvalid & tready_c;
   assign aw_hs      = aw_vld_q & M_AXI_awready;
   assign w_hs       = w_vld_q & M_AXI_wready;
   assign b_hs       = M_AXI_bvalid & bready_c;
   assign SM_reading = accept;
   assign SM_writing = b_hs;

   // run_q keeps tready low while reset is held and for the release cycle.
   always_comb begin
      state_d  = state_q;
      tready_c = 1'b0;
      bready_c = 1'b0;
      case (state_q)
         IDLE: begin
            tready_c = run_q;
            if (S_AXIS_tvalid && run_q) state_d = XFER;
         end
         XFER: begin
            if ((!aw_vld_q || M_AXI_awready) && (!w_vld_q || M_AXI_wready))
               state_d = RESP;
         end
         RESP: begin
            bready_c = 1'b1;
            if (M_AXI_bvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         state_q  <= IDLE;
         run_q    <= 1'b0;
         beat_q   <= '0;
         aw_vld_q <= 1'b0;
         w_vld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (accept) begin
            beat_q.addr <= SM_write_buffer;
            beat_q.dat  <= S_AXIS_tdata;
            aw_vld_q    <= 1'b1;
            w_vld_q     <= 1'b1;
         end else begin
            if (aw_hs) aw_vld_q <= 1'b0;
            if (w_hs)  w_vld_q  <= 1'b0;
         end
      end
   end

`ifdef S2MM_WRITER_ERROR_COUNT_EN
   logic [31:0] err_cnt_q;

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn)
         err_cnt_q <= '0;
      else if (b_hs && (M_AXI_bresp != 2'b00) && (err_cnt_q != 32'hFFFF_FFFF))
         err_cnt_q <= err_cnt_q + 32'd1;
   end

   assign S2MM_error_count = err_cnt_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^M_AXI_bresp;
`endif

endmodule
